// File: rtl/crop_pkg.sv
// Shared definitions for the crop scheduler: default geometry, request field
// widths and the controller state encoding.
package crop_pkg;

    localparam int IN_ROWS_DEF   = 40;
    localparam int IN_COLS_DEF   = 40;
    localparam int OUT_ROWS_DEF  = 20;
    localparam int OUT_COLS_DEF  = 20;
    localparam int ROW_W         = 10;
    localparam int COL_W         = 10;
    localparam int REQ_W         = ROW_W + COL_W;
    localparam int REQ_DEPTH_DEF = 4;

    localparam int FRAME_PIXELS  = IN_ROWS_DEF * IN_COLS_DEF;
    localparam int CROP_PIXELS   = OUT_ROWS_DEF * OUT_COLS_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } crop_state_e;

endpackage

// File: rtl/crop_req_fifo.sv
// Small synchronous request FIFO holding packed {Y1, X1} crop boxes.
// Pushes while full and pops while empty are ignored.
module crop_req_fifo
    import crop_pkg::*;
#(
    parameter int WIDTH = REQ_W,
    parameter int DEPTH = REQ_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/crop_scheduler.sv
// Per-frame crop controller: queues crop boxes, clamps them into the image,
// hands them to the filter, gates the pixel stream and checks pixel counts.
module crop_scheduler
    import crop_pkg::*;
#(
    parameter int IN_ROWS          = IN_ROWS_DEF,
    parameter int IN_COLS          = IN_COLS_DEF,
    parameter int OUT_ROWS         = OUT_ROWS_DEF,
    parameter int OUT_COLS         = OUT_COLS_DEF,
    parameter int IMG_ROW_BITWIDTH = ROW_W,
    parameter int IMG_COL_BITWIDTH = COL_W,
    parameter int REQ_DEPTH        = REQ_DEPTH_DEF
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] req_TDATA,
    input  logic                                       req_TVALID,
    output logic                                       req_TREADY,
    output logic [IMG_ROW_BITWIDTH-1:0]                crop_Y1_TDATA,
    output logic                                       crop_Y1_TVALID,
    input  logic                                       crop_Y1_TREADY,
    output logic [IMG_COL_BITWIDTH-1:0]                crop_X1_TDATA,
    output logic                                       crop_X1_TVALID,
    input  logic                                       crop_X1_TREADY,
    input  logic                                       pix_in_hs,
    input  logic                                       pix_out_hs,
    output logic                                       pixel_gate,
    output logic                                       frame_done,
    output logic                                       clamped,
    output logic                                       crop_err
);

    localparam int RQW       = IMG_ROW_BITWIDTH + IMG_COL_BITWIDTH;
    localparam int FRAME_PIX = IN_ROWS * IN_COLS;
    localparam int CROP_PIX  = OUT_ROWS * OUT_COLS;
    localparam int CNT_W     = $clog2(FRAME_PIX) + 1;

    localparam logic [CNT_W-1:0]            FRAME_LAST  = CNT_W'(FRAME_PIX - 1);
    localparam logic [CNT_W-1:0]            CROP_TARGET = CNT_W'(CROP_PIX);
    localparam logic [CNT_W-1:0]            CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [IMG_ROW_BITWIDTH-1:0] Y_MAX       = IMG_ROW_BITWIDTH'(IN_ROWS - OUT_ROWS);
    localparam logic [IMG_COL_BITWIDTH-1:0] X_MAX       = IMG_COL_BITWIDTH'(IN_COLS - OUT_COLS);

    crop_state_e                 state_r;
    crop_state_e                 state_n;

    logic                        ready_r;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic                        fifo_push_s;
    logic                        pop_s;
    logic [RQW-1:0]              head_s;
    logic [IMG_ROW_BITWIDTH-1:0] head_y_s;
    logic [IMG_COL_BITWIDTH-1:0] head_x_s;
    logic [IMG_ROW_BITWIDTH-1:0] y_clamp_s;
    logic [IMG_COL_BITWIDTH-1:0] x_clamp_s;
    logic                        y_over_s;
    logic                        x_over_s;

    logic [IMG_ROW_BITWIDTH-1:0] y_data_r;
    logic [IMG_COL_BITWIDTH-1:0] x_data_r;
    logic                        y_valid_r;
    logic                        x_valid_r;
    logic                        gate_r;
    logic                        done_r;
    logic                        clamped_r;
    logic                        err_r;

    logic [CNT_W-1:0]            pix_cnt_r;
    logic [CNT_W-1:0]            crop_cnt_r;
    logic [CNT_W-1:0]            crop_total_s;
    logic                        pix_in_acc_s;

    assign req_TREADY  = ready_r & ~fifo_full_s;
    assign fifo_push_s = req_TVALID & req_TREADY;

    crop_req_fifo #(
        .WIDTH (RQW),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push_s),
        .push_data (req_TDATA),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign head_y_s  = head_s[RQW-1 -: IMG_ROW_BITWIDTH];
    assign head_x_s  = head_s[IMG_COL_BITWIDTH-1:0];
    assign y_over_s  = (head_y_s > Y_MAX);
    assign x_over_s  = (head_x_s > X_MAX);
    assign y_clamp_s = y_over_s ? Y_MAX : head_y_s;
    assign x_clamp_s = x_over_s ? X_MAX : head_x_s;

    // Pixels offered while the gate is closed are an integration fault and never count.
    assign pix_in_acc_s = pix_in_hs & gate_r;
    assign crop_total_s = crop_cnt_r + CNT_W'(pix_out_hs);

    // Controller state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode and FIFO pop request.
    always_comb begin
        state_n = state_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_n = ST_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if ((!y_valid_r || crop_Y1_TREADY) && (!x_valid_r || crop_X1_TREADY)) begin
                    state_n = ST_RUN;
                end else begin
                    state_n = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (pix_in_acc_s && (pix_cnt_r == FRAME_LAST)) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_n = ST_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Coordinate channels, gate, frame pulse and clamp flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r   <= 1'b0;
            y_data_r  <= {IMG_ROW_BITWIDTH{1'b0}};
            x_data_r  <= {IMG_COL_BITWIDTH{1'b0}};
            y_valid_r <= 1'b0;
            x_valid_r <= 1'b0;
            gate_r    <= 1'b0;
            done_r    <= 1'b0;
            clamped_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
            gate_r  <= (state_n == ST_RUN);
            done_r  <= (state_n == ST_DONE);
            if (pop_s) begin
                y_data_r  <= y_clamp_s;
                x_data_r  <= x_clamp_s;
                y_valid_r <= 1'b1;
                x_valid_r <= 1'b1;
                if (y_over_s || x_over_s) begin
                    clamped_r <= 1'b1;
                end
            end else begin
                if (y_valid_r && crop_Y1_TREADY) begin
                    y_valid_r <= 1'b0;
                end
                if (x_valid_r && crop_X1_TREADY) begin
                    x_valid_r <= 1'b0;
                end
            end
        end
    end

    // Frame and crop pixel counters plus the end-of-frame count check.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt_r  <= {CNT_W{1'b0}};
            crop_cnt_r <= {CNT_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (pix_in_acc_s) begin
                        pix_cnt_r <= pix_cnt_r + CNT_W'(1);
                    end
                    if (pix_out_hs && (crop_cnt_r != CNT_MAX)) begin
                        crop_cnt_r <= crop_cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    pix_cnt_r  <= {CNT_W{1'b0}};
                    crop_cnt_r <= {CNT_W{1'b0}};
                    if (crop_total_s != CROP_TARGET) begin
                        err_r <= 1'b1;
                    end
                end
                default: begin
                    pix_cnt_r  <= pix_cnt_r;
                    crop_cnt_r <= crop_cnt_r;
                end
            endcase
        end
    end

    assign crop_Y1_TDATA  = y_data_r;
    assign crop_X1_TDATA  = x_data_r;
    assign crop_Y1_TVALID = y_valid_r;
    assign crop_X1_TVALID = x_valid_r;
    assign pixel_gate     = gate_r;
    assign frame_done     = done_r;
    assign clamped        = clamped_r;
    assign crop_err       = err_r;

endmodule

// File: tb/tb_crop_scheduler.sv
// Self-checking bench for crop_scheduler against a frame-level reference model.
module tb_crop_scheduler;

    localparam int IN_ROWS = 40, IN_COLS = 40, OUT_ROWS = 20, OUT_COLS = 20;
    localparam int RW = 10, CW = 10, REQ_DEPTH = 4;
    localparam int FRAME = IN_ROWS * IN_COLS;
    localparam int CROP  = OUT_ROWS * OUT_COLS;
    localparam int Y_LIM = IN_ROWS - OUT_ROWS;
    localparam int X_LIM = IN_COLS - OUT_COLS;

    logic clk = 1'b0;
    logic reset;
    logic [RW+CW-1:0] req_TDATA;
    logic req_TVALID, req_TREADY;
    logic [RW-1:0] crop_Y1_TDATA;
    logic [CW-1:0] crop_X1_TDATA;
    logic crop_Y1_TVALID, crop_Y1_TREADY, crop_X1_TVALID, crop_X1_TREADY;
    logic pix_in_hs, pix_out_hs, pixel_gate, frame_done, clamped, crop_err;

    int checks = 0;
    int failures = 0;
    int exp_y_q[$];
    int exp_x_q[$];
    bit exp_clamped = 1'b0;
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    crop_scheduler dut (
        .clk(clk), .reset(reset),
        .req_TDATA(req_TDATA), .req_TVALID(req_TVALID), .req_TREADY(req_TREADY),
        .crop_Y1_TDATA(crop_Y1_TDATA), .crop_Y1_TVALID(crop_Y1_TVALID), .crop_Y1_TREADY(crop_Y1_TREADY),
        .crop_X1_TDATA(crop_X1_TDATA), .crop_X1_TVALID(crop_X1_TVALID), .crop_X1_TREADY(crop_X1_TREADY),
        .pix_in_hs(pix_in_hs), .pix_out_hs(pix_out_hs), .pixel_gate(pixel_gate),
        .frame_done(frame_done), .clamped(clamped), .crop_err(crop_err)
    );

    function automatic int clamp_model(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input int y, input int x, output bit ok);
        req_TDATA  = {RW'(y), CW'(x)};
        req_TVALID = 1'b1;
        ok = 1'b0;
        for (int g = 0; g < 8 && !ok; g++) begin
            if (req_TREADY) ok = 1'b1;
            tick();
        end
        req_TVALID = 1'b0;
        if (ok) begin
            exp_y_q.push_back(clamp_model(y, Y_LIM));
            exp_x_q.push_back(clamp_model(x, X_LIM));
            if (y > Y_LIM || x > X_LIM) exp_clamped = 1'b1;
        end
    endtask

    // Waits for the box, releases each channel after its own delay, reports what it saw.
    task automatic do_load(input int y_dly, input int x_dly,
                           output int y_val, output int x_val, output int y_cyc, output int x_cyc,
                           output bit stable, output bit gate_early, output bit timeout);
        int guard = 0;
        int k = 0;
        y_val = -1; x_val = -1; y_cyc = 0; x_cyc = 0;
        stable = 1'b1; gate_early = 1'b0; timeout = 1'b0;
        while (!(crop_Y1_TVALID && crop_X1_TVALID) && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) begin
            timeout = 1'b1;
        end else begin
            y_val = int'(crop_Y1_TDATA);
            x_val = int'(crop_X1_TDATA);
            while ((crop_Y1_TVALID || crop_X1_TVALID) && k < 64) begin
                crop_Y1_TREADY = (k >= y_dly);
                crop_X1_TREADY = (k >= x_dly);
                if (crop_Y1_TVALID) begin
                    y_cyc++;
                    if (int'(crop_Y1_TDATA) != y_val) stable = 1'b0;
                end
                if (crop_X1_TVALID) begin
                    x_cyc++;
                    if (int'(crop_X1_TDATA) != x_val) stable = 1'b0;
                end
                if (pixel_gate) gate_early = 1'b1;
                tick();
                k++;
            end
            if (k >= 64) timeout = 1'b1;
        end
        crop_Y1_TREADY = 1'b0;
        crop_X1_TREADY = 1'b0;
    endtask

    // Streams n_px accepted pixels with random gaps; optionally the last crop pixel lands in the DONE cycle.
    task automatic run_pixels(input int n_px, input int n_out, input bit out_in_done,
                              output int early_done, output int gate_low,
                              output bit done_end, output bit gate_end,
                              output bit done_after, output bit err_after);
        int sent = 0;
        int outs = 0;
        int n_run = out_in_done ? n_out - 1 : n_out;
        early_done = 0;
        gate_low = 0;
        while (sent < n_px) begin
            if (frame_done) early_done++;
            if (!pixel_gate) gate_low++;
            if ($urandom_range(0, 7) == 0) begin
                pix_in_hs = 1'b0;
                pix_out_hs = 1'b0;
            end else begin
                pix_in_hs = 1'b1;
                sent++;
                pix_out_hs = (outs < n_run);
                if (outs < n_run) outs++;
            end
            tick();
        end
        pix_in_hs = 1'b0;
        pix_out_hs = 1'b0;
        done_end = frame_done;
        gate_end = pixel_gate;
        pix_out_hs = out_in_done;
        tick();
        pix_out_hs = 1'b0;
        done_after = frame_done;
        err_after = crop_err;
        if (n_out != CROP) exp_err = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_TDATA = '0; req_TVALID = 1'b0;
        crop_Y1_TREADY = 1'b0; crop_X1_TREADY = 1'b0;
        pix_in_hs = 1'b0; pix_out_hs = 1'b0;
        tick(); tick();
        checks++;
        if ({req_TREADY, crop_Y1_TVALID, crop_X1_TVALID, pixel_gate, frame_done, clamped, crop_err} !== 7'b0 ||
            crop_Y1_TDATA !== 10'd0 || crop_X1_TDATA !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b yv=%b xv=%b gate=%b done=%b clamp=%b err=%b y=%0d x=%0d required all zero",
                     req_TREADY, crop_Y1_TVALID, crop_X1_TVALID, pixel_gate, frame_done, clamped, crop_err,
                     crop_Y1_TDATA, crop_X1_TDATA);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (req_TREADY !== 1'b1 || pixel_gate !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got rdy=%b gate=%b required rdy=1 gate=0", req_TREADY, pixel_gate);
        end
    endtask

    task automatic test_single();
        bit ok, st, ge, to, de, gend, da, ea;
        int yv, xv, yc, xc, ed, gl, ey, ex;
        push_req(5, 7, ok);
        ey = exp_y_q.pop_front(); ex = exp_x_q.pop_front();
        do_load(0, 0, yv, xv, yc, xc, st, ge, to);
        checks++;
        if (!ok || to || yv !== ey || xv !== ex) begin
            failures++;
            $display("FAIL single_data got y=%0d x=%0d push=%b timeout=%b required y=%0d x=%0d", yv, xv, ok, to, ey, ex);
        end
        checks++;
        if (yc !== 1 || xc !== 1 || ge !== 1'b0) begin
            failures++;
            $display("FAIL single_valid_len got ycyc=%0d xcyc=%0d gate_early=%b required 1 1 0", yc, xc, ge);
        end
        checks++;
        if (pixel_gate !== 1'b1) begin
            failures++;
            $display("FAIL single_gate_rise got %b required 1", pixel_gate);
        end
        run_pixels(FRAME, CROP, 1'b0, ed, gl, de, gend, da, ea);
        checks++;
        if (ed !== 0 || gl !== 0 || de !== 1'b1 || gend !== 1'b0 || da !== 1'b0) begin
            failures++;
            $display("FAIL single_frame_done got early=%0d gate_low=%0d done=%b gate=%b done_next=%b required 0 0 1 0 0",
                     ed, gl, de, gend, da);
        end
        checks++;
        if (ea !== exp_err || clamped !== exp_clamped) begin
            failures++;
            $display("FAIL single_flags got err=%b clamped=%b required err=%b clamped=%b", ea, clamped, exp_err, exp_clamped);
        end
    endtask

    task automatic test_clamp();
        bit ok, st, ge, to, de, gend, da, ea;
        int yv, xv, yc, xc, ed, gl, ey, ex;
        push_req(30, 25, ok);
        ey = exp_y_q.pop_front(); ex = exp_x_q.pop_front();
        do_load(0, 0, yv, xv, yc, xc, st, ge, to);
        checks++;
        if (!ok || to || yv !== ey || xv !== ex) begin
            failures++;
            $display("FAIL clamp_data got y=%0d x=%0d timeout=%b required y=%0d x=%0d", yv, xv, to, ey, ex);
        end
        checks++;
        if (clamped !== exp_clamped) begin
            failures++;
            $display("FAIL clamp_flag got %b required %b", clamped, exp_clamped);
        end
        run_pixels(FRAME, CROP, 1'b1, ed, gl, de, gend, da, ea);
        checks++;
        if (de !== 1'b1 || ea !== exp_err) begin
            failures++;
            $display("FAIL clamp_frame got done=%b err=%b required done=1 err=%b", de, ea, exp_err);
        end
    endtask

    task automatic test_delayed_x();
        bit ok, st, ge, to, de, gend, da, ea;
        int yv, xv, yc, xc, ed, gl, ey, ex;
        push_req($urandom_range(0, 20), $urandom_range(0, 20), ok);
        ey = exp_y_q.pop_front(); ex = exp_x_q.pop_front();
        do_load(0, 3, yv, xv, yc, xc, st, ge, to);
        checks++;
        if (to || yc !== 1 || xc !== 4 || st !== 1'b1) begin
            failures++;
            $display("FAIL delayed_x_valid got ycyc=%0d xcyc=%0d stable=%b timeout=%b required 1 4 1 0", yc, xc, st, to);
        end
        checks++;
        if (yv !== ey || xv !== ex) begin
            failures++;
            $display("FAIL delayed_x_data got y=%0d x=%0d required y=%0d x=%0d", yv, xv, ey, ex);
        end
        checks++;
        if (ge !== 1'b0 || pixel_gate !== 1'b1) begin
            failures++;
            $display("FAIL delayed_x_run_entry got gate_during_load=%b gate_after=%b required 0 1", ge, pixel_gate);
        end
        run_pixels(FRAME, CROP, 1'b0, ed, gl, de, gend, da, ea);
        checks++;
        if (ed !== 0 || de !== 1'b1 || ea !== exp_err) begin
            failures++;
            $display("FAIL delayed_x_frame got early=%0d done=%b err=%b required 0 1 %b", ed, de, ea, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, all_ok, st, ge, to, de, gend, da, ea;
        int yv, xv, yc, xc, ed, gl, ey, ex, pushes;
        all_ok = 1'b1;
        pushes = 0;
        for (int i = 0; i < 5; i++) begin
            push_req($urandom_range(0, 30), $urandom_range(0, 30), ok);
            if (ok) pushes++;
            all_ok = all_ok & ok;
        end
        checks++;
        if (!all_ok || req_TREADY !== ((pushes - 1) < REQ_DEPTH)) begin
            failures++;
            $display("FAIL b2b_fifo_full got pushes=%0d ready=%b required pushes=5 ready=%b",
                     pushes, req_TREADY, (pushes - 1) < REQ_DEPTH);
        end
        for (int f = 0; f < 5; f++) begin
            ey = exp_y_q.pop_front(); ex = exp_x_q.pop_front();
            do_load($urandom_range(0, 3), $urandom_range(0, 3), yv, xv, yc, xc, st, ge, to);
            checks++;
            if (to || yv !== ey || xv !== ex || st !== 1'b1) begin
                failures++;
                $display("FAIL b2b_order frame=%0d got y=%0d x=%0d stable=%b timeout=%b required y=%0d x=%0d",
                         f, yv, xv, st, to, ey, ex);
            end
            run_pixels(FRAME, CROP, 1'($urandom_range(0, 1)), ed, gl, de, gend, da, ea);
            checks++;
            if (de !== 1'b1 || ed !== 0 || ea !== exp_err) begin
                failures++;
                $display("FAIL b2b_done frame=%0d got done=%b early=%0d err=%b required 1 0 %b", f, de, ed, ea, exp_err);
            end
            checks++;
            if (crop_Y1_TVALID !== (exp_y_q.size() > 0) || crop_X1_TVALID !== (exp_x_q.size() > 0)) begin
                failures++;
                $display("FAIL b2b_next_load frame=%0d got yv=%b xv=%b required %b",
                         f, crop_Y1_TVALID, crop_X1_TVALID, exp_y_q.size() > 0);
            end
        end
        checks++;
        if (clamped !== exp_clamped) begin
            failures++;
            $display("FAIL b2b_clamped got %b required %b", clamped, exp_clamped);
        end
    endtask

    task automatic test_crop_err();
        bit ok, st, ge, to, de, gend, da, ea;
        int yv, xv, yc, xc, ed, gl, ey, ex;
        int outs[2] = '{CROP - 1, CROP};
        for (int f = 0; f < 2; f++) begin
            push_req($urandom_range(0, 20), $urandom_range(0, 20), ok);
            ey = exp_y_q.pop_front(); ex = exp_x_q.pop_front();
            do_load(0, 0, yv, xv, yc, xc, st, ge, to);
            run_pixels(FRAME, outs[f], 1'b0, ed, gl, de, gend, da, ea);
            checks++;
            if (!ok || to || de !== 1'b1 || ea !== exp_err) begin
                failures++;
                $display("FAIL crop_err frame=%0d outs=%0d got done=%b err=%b timeout=%b required done=1 err=%b",
                         f, outs[f], de, ea, to, exp_err);
            end
        end
    endtask

    task automatic test_random();
        bit ok, st, ge, to, de, gend, da, ea;
        int yv, xv, yc, xc, ed, gl, ey, ex, y, x, no;
        for (int f = 0; f < 3; f++) begin
            y = ($urandom_range(0, 3) == 0) ? 1023 : $urandom_range(0, 40);
            x = ($urandom_range(0, 3) == 0) ? 1023 : $urandom_range(0, 40);
            no = CROP - 1 + $urandom_range(0, 2);
            push_req(y, x, ok);
            ey = exp_y_q.pop_front(); ex = exp_x_q.pop_front();
            do_load($urandom_range(0, 4), $urandom_range(0, 4), yv, xv, yc, xc, st, ge, to);
            checks++;
            if (!ok || to || yv !== ey || xv !== ex || clamped !== exp_clamped) begin
                failures++;
                $display("FAIL random_load y_in=%0d x_in=%0d got y=%0d x=%0d clamped=%b required y=%0d x=%0d clamped=%b",
                         y, x, yv, xv, clamped, ey, ex, exp_clamped);
            end
            run_pixels(FRAME, no, 1'($urandom_range(0, 1)), ed, gl, de, gend, da, ea);
            checks++;
            if (de !== 1'b1 || ed !== 0 || gend !== 1'b0 || ea !== exp_err) begin
                failures++;
                $display("FAIL random_frame outs=%0d got done=%b early=%0d gate=%b err=%b required 1 0 0 %b",
                         no, de, ed, gend, ea, exp_err);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok, ok2, st, ge, to, de, gend, da, ea;
        int yv, xv, yc, xc, ed, gl, ey, ex;
        push_req(35, 3, ok);
        push_req(6, 9, ok2);
        do_load(0, 0, yv, xv, yc, xc, st, ge, to);
        for (int i = 0; i < FRAME / 2; i++) begin
            pix_in_hs = 1'b1;
            pix_out_hs = (i < CROP / 2);
            tick();
        end
        pix_in_hs = 1'b0;
        pix_out_hs = 1'b0;
        reset = 1'b0;
        #1;
        exp_y_q.delete(); exp_x_q.delete();
        exp_clamped = 1'b0; exp_err = 1'b0;
        checks++;
        if ({req_TREADY, crop_Y1_TVALID, crop_X1_TVALID, pixel_gate, frame_done, clamped, crop_err} !== 7'b0 ||
            crop_Y1_TDATA !== 10'd0 || crop_X1_TDATA !== 10'd0) begin
            failures++;
            $display("FAIL midreset_async got rdy=%b yv=%b xv=%b gate=%b done=%b clamp=%b err=%b required all zero",
                     req_TREADY, crop_Y1_TVALID, crop_X1_TVALID, pixel_gate, frame_done, clamped, crop_err);
        end
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pix_in_hs = 1'b1;
            tick();
        end
        pix_in_hs = 1'b0;
        checks++;
        if (crop_Y1_TVALID !== 1'b0 || pixel_gate !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_queue_flushed got yv=%b gate=%b done=%b required 0 0 0",
                     crop_Y1_TVALID, pixel_gate, frame_done);
        end
        push_req(4, 11, ok);
        ey = exp_y_q.pop_front(); ex = exp_x_q.pop_front();
        do_load(0, 0, yv, xv, yc, xc, st, ge, to);
        checks++;
        if (!ok || to || yv !== ey || xv !== ex) begin
            failures++;
            $display("FAIL midreset_new_req got y=%0d x=%0d timeout=%b required y=%0d x=%0d", yv, xv, to, ey, ex);
        end
        run_pixels(FRAME, CROP, 1'b0, ed, gl, de, gend, da, ea);
        checks++;
        if (ed !== 0 || de !== 1'b1 || ea !== 1'b0 || clamped !== 1'b0) begin
            failures++;
            $display("FAIL midreset_full_frame got early=%0d done=%b err=%b clamped=%b required 0 1 0 0",
                     ed, de, ea, clamped);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clamp();
        test_delayed_x();
        test_back_to_back();
        test_crop_err();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
